ram_arbiter_2port: RTL
======================

Name: ram_arbiter_2port

Overview:
- Shares the single-port 32x2048 word RAM (1-cycle registered read, write-then-read on the same edge) between the CPU instruction-fetch port (read-only) and data port (read/write).
- Waitrequest-style handshake on both CPU ports; the block translates byte addresses to word indices and sequences every RAM access.
- Sits between the CPU core and the RAM in the test harness.

Parameters:
ADDR_W, 11, RAM word-index width (2048 words); byte-address bits [ADDR_W+1:2] select the word
RR_RESET_LAST, 1, last-grant value after reset (1 = data, so the instruction port wins the first tie)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
i_address  input  32  instruction byte address
i_read  input  1  instruction read request, held until i_waitrequest low
i_waitrequest  output  1  high = instruction request not yet complete
i_readdata  output  32  instruction word, valid while i_read && !i_waitrequest
d_address  input  32  data byte address
d_read  input  1  data read request
d_write  input  1  data write request
d_writedata  input  32  write data
d_waitrequest  output  1  high = data request not yet complete
d_readdata  output  32  data word, valid while d_read && !d_waitrequest
ram_address  output  32  word index to RAM, {(32-ADDR_W)'b0, addr[ADDR_W+1:2]}
ram_read  output  1  RAM read strobe
ram_write  output  1  RAM write strobe
ram_writedata  output  32  RAM write data
ram_readdata  input  32  RAM registered read data (valid the cycle after the issuing edge)

Behaviour:
- FSM states IDLE, ACCESS, RESP; owner register (I/D); last_grant register; latched op, addr, wdata.
- Reset (async, reset_n=0): state=IDLE, owner=I, last_grant=RR_RESET_LAST, latches=0. ram_read, ram_write, ram_address and ram_writedata are 0. i_readdata and d_readdata are 0. The waitrequests equal their port's request.
- IDLE: if no requests, stay in IDLE. If one port requests, grant it.
- IDLE, both ports requesting: grant the port not equal to last_grant.
- On grant, latch the address word index, writedata and op, then go to ACCESS.
- Data port with d_read and d_write both high: write wins and no read is performed; the bench flags this as illegal.
- ACCESS (1 cycle): drive ram_address and ram_writedata from the latches. Drive ram_write=1 for a write op, otherwise ram_read=1. At the end of ACCESS the RAM performs the op; go to RESP.
- RESP (1 cycle): owner's waitrequest is 0. Owner's readdata = ram_readdata; for a write this is the read-after-write value, and requesters ignore it. Set last_grant=owner.
- Leaving RESP: if the other port is requesting, grant it and go directly to ACCESS (skip IDLE). Otherwise go to IDLE.
- The owner's request in RESP is never re-granted, even if still asserted.
- Waitrequest (combinational): x_waitrequest = x_request && !(state==RESP && owner==x).
- Readdata (combinational): x_readdata = ram_readdata when state==RESP && owner==x, else 0.
- Latency: request first seen in cycle 0 → waitrequest low in cycle 2 (3 cycles per access; back-to-back alternating accesses complete every 2 cycles).
- Outside ACCESS: ram_read=ram_write=0, ram_address and ram_writedata hold their last values.
- Address bits [1:0] and bits above ADDR_W+1 are ignored; wrap-around is silent.
- Request dropped by the requester before completion: the access still completes and RESP is consumed; no retry.
- Reset mid-ACCESS: ram_write falls immediately (async). The RAM may or may not capture that edge; the bench does not check memory contents after a mid-access reset.

Decomposition:
- Shared package mem_arb_pkg: enum state_t {IDLE, ACCESS, RESP}, enum port_t {PORT_I, PORT_D}, op encoding (OP_RD, OP_WR), WORD_BYTES=4.
- One natural sub-module: rr_arbiter_2 (2-request round-robin pick from last_grant, purely combinational). The FSM stays in the top module.

Test Plan:
- Reset release, no requests → all RAM strobes 0, both waitrequests 0, readdata 0 for 10 cycles.
- d_write addr 0x0000_0010 data 0xDEADBEEF then d_read 0x10 → ram_address=4, ram_write pulse 1 cycle; read returns 0xDEADBEEF in cycle 2 of the read with d_waitrequest low exactly 1 cycle.
- i_read 0x0 and d_read 0x4 asserted in the same cycle after reset → I served first (i_waitrequest low in cycle 2), D goes ACCESS directly from RESP (d_waitrequest low in cycle 4).
- Both ports requesting continuously for 8 accesses → grants alternate I,D,I,D,…; no port is granted twice in a row.
- Byte address 0x0000_2003 with ADDR_W=11 → ram_address=0 (bits above 12 and [1:0] ignored).
- reset_n pulled low during ACCESS of a write → ram_write 0 the same cycle, FSM in IDLE after release, next i_read completes normally in 3 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, port ids, op codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   localparam int WORD_BYTES = 4;
   localparam int WORD_SHIFT = $clog2(WORD_BYTES);

   function automatic port_t other_port(input port_t p);
      return (p == PORT_I) ? PORT_D : PORT_I;
   endfunction

endpackage

// File: rtl/ram_arbiter_2port_rr.sv
// Two-request round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   req_i, req_d  request from instruction / data port
//   last_grant    port that completed the most recent access
//   gnt_vld       at least one request present
//   gnt_port      chosen port (meaningful only when gnt_vld)
module rr_arbiter_2
   import mem_arb_pkg::*;
(
   input  logic  req_i,
   input  logic  req_d,
   input  port_t last_grant,
   output logic  gnt_vld,
   output port_t gnt_port
);

   always_comb begin
      gnt_vld  = req_i | req_d;
      gnt_port = PORT_I;
      if (req_i && req_d) begin
         gnt_port = other_port(last_grant);
      end else if (req_d) begin
         gnt_port = PORT_D;
      end
   end

endmodule

// File: rtl/ram_arbiter_2port.sv
// Shares one single-port word RAM between the CPU instruction-fetch (read-only) and data (read/write) ports.
// Latency: request seen in cycle 0 -> waitrequest low in cycle 2; alternating back-to-back accesses every 2 cycles.
// Backpressure: waitrequest held high on each port until its RESP cycle; one access in flight at a time.
//
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   i_address/i_read                      instruction byte address and read request
//   i_waitrequest/i_readdata              instruction handshake and returned word
//   d_address/d_read/d_write/d_writedata  data byte address, requests, write data
//   d_waitrequest/d_readdata              data handshake and returned word
//   ram_address/ram_read/ram_write/ram_writedata/ram_readdata  RAM side (word index, strobes, data)
module ram_arbiter_2port
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W        = 11,
   parameter bit RR_RESET_LAST = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] ram_address,
   output logic        ram_read,
   output logic        ram_write,
   output logic [31:0] ram_writedata,
   input  logic [31:0] ram_readdata
);

   localparam int AHI = ADDR_W + WORD_SHIFT - 1;

   state_t              state, state_nxt;
   port_t               owner, last_grant;
   op_t                 lat_op;
   logic [ADDR_W-1:0]   lat_addr;
   logic [31:0]         lat_wdata;

   logic                i_req, d_req;
   logic                arb_vld;
   port_t               arb_port;
   logic                grant_en;
   port_t               grant_port;
   logic                other_req;

   // Byte-offset bits and bits above the RAM size are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_address[31:AHI+1], i_address[WORD_SHIFT-1:0],
                               d_address[31:AHI+1], d_address[WORD_SHIFT-1:0]};

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   rr_arbiter_2 u_rr (
      .req_i      (i_req),
      .req_d      (d_req),
      .last_grant (last_grant),
      .gnt_vld    (arb_vld),
      .gnt_port   (arb_port)
   );

   // Only the port that did not just complete may chain straight from RESP to ACCESS.
   assign other_req = (owner == PORT_I) ? d_req : i_req;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and grant decision
   always_comb begin
      state_nxt  = state;
      grant_en   = 1'b0;
      grant_port = arb_port;
      case (state)
         IDLE: begin
            if (arb_vld) begin
               state_nxt  = ACCESS;
               grant_en   = 1'b1;
               grant_port = arb_port;
            end
         end
         ACCESS: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (other_req) begin
               state_nxt  = ACCESS;
               grant_en   = 1'b1;
               grant_port = other_port(owner);
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Owner, fairness history and request latches
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner      <= PORT_I;
         last_grant <= port_t'(RR_RESET_LAST);
         lat_op     <= OP_RD;
         lat_addr   <= '0;
         lat_wdata  <= '0;
      end else begin
         if (state == RESP) begin
            last_grant <= owner;
         end
         if (grant_en) begin
            owner <= grant_port;
            if (grant_port == PORT_D) begin
               lat_addr  <= d_address[AHI:WORD_SHIFT];
               lat_wdata <= d_writedata;
               // A simultaneous read+write collapses to a write.
               lat_op    <= d_write ? OP_WR : OP_RD;
            end else begin
               lat_addr  <= i_address[AHI:WORD_SHIFT];
               lat_op    <= OP_RD;
            end
         end
      end
   end

   // Address/data come straight from the latches, so they hold between accesses.
   assign ram_address   = {{(32-ADDR_W){1'b0}}, lat_addr};
   assign ram_writedata = lat_wdata;

   // Outputs
   always_comb begin
      ram_read      = 1'b0;
      ram_write     = 1'b0;
      i_waitrequest = i_req;
      d_waitrequest = d_req;
      i_readdata    = '0;
      d_readdata    = '0;
      if (state == ACCESS) begin
         ram_write = (lat_op == OP_WR);
         ram_read  = (lat_op == OP_RD);
      end
      if (state == RESP) begin
         if (owner == PORT_I) begin
            i_waitrequest = 1'b0;
            i_readdata    = ram_readdata;
         end else begin
            d_waitrequest = 1'b0;
            d_readdata    = ram_readdata;
         end
      end
   end

endmodule
